// File: rtl/bit_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bit_capture_pkg
// Description : Shared types and register/function codes for bit_capture.
// Revision    : 1.0 - initial release
// ============================================================================
package bit_capture_pkg;

  // Handshake controller states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACK     = 2'd1,
    ST_WAIT_LO = 2'd2
  } hs_state_t;

  // Register select codes
  localparam logic [1:0] SEL_RISE   = 2'd0;
  localparam logic [1:0] SEL_FALL   = 2'd1;
  localparam logic [1:0] SEL_WIDTH  = 2'd2;
  localparam logic [1:0] SEL_STATUS = 2'd3;

  // Request function codes
  localparam logic FN_READ  = 1'b0;
  localparam logic FN_CLEAR = 1'b1;

endpackage : bit_capture_pkg
`default_nettype wire

// File: rtl/sync_bit.sv
`default_nettype none
// ============================================================================
// Module      : sync_bit
// Description : Multi-flop synchronizer bringing an asynchronous bit into clk.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_shift;

  // Shift the raw input through the flop chain; oldest sample is the output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
    end else begin
      r_shift <= {r_shift[STAGES-2:0], d};
    end
  end

  assign q = r_shift[STAGES-1];

endmodule : sync_bit
`default_nettype wire

// File: rtl/bit_capture.sv
`default_nettype none
// ============================================================================
// Module      : bit_capture
// Description : Counts rising/falling edges and high-pulse width of an
//               asynchronous bit stream; results read or cleared through a
//               four-phase req/ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_capture
  import bit_capture_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
  input  logic        req,
  input  logic        fn,
  input  logic [1:0]  sel,
  output logic        ack,
  output logic [31:0] rd_data
);

  localparam logic [CNT_W-1:0] C_MAX = '1;
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  logic             w_lvl;
  logic             r_lvl_d;
  logic             w_rise;
  logic             w_fall;
  logic [CNT_W-1:0] r_rise_cnt;
  logic [CNT_W-1:0] r_fall_cnt;
  logic [CNT_W-1:0] r_width_cnt;
  logic [CNT_W-1:0] r_last_width;
  logic             r_rise_ovf;
  logic             r_fall_ovf;
  logic             r_width_ovf;
  hs_state_t        r_state;
  hs_state_t        w_next;
  logic             w_take;
  logic             w_clear;
  logic [31:0]      w_sel_val;
  logic [31:0]      r_snap;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (din),
    .q   (w_lvl)
  );

  // Previous synchronized level, for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lvl_d <= 1'b0;
    end else begin
      r_lvl_d <= w_lvl;
    end
  end

  assign w_rise = w_lvl & ~r_lvl_d;
  assign w_fall = ~w_lvl & r_lvl_d;

  // Saturating edge counters with sticky overflow; a clear overrides any edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rise_cnt <= '0;
      r_fall_cnt <= '0;
      r_rise_ovf <= 1'b0;
      r_fall_ovf <= 1'b0;
    end else if (w_clear) begin
      r_rise_cnt <= '0;
      r_fall_cnt <= '0;
      r_rise_ovf <= 1'b0;
      r_fall_ovf <= 1'b0;
    end else begin
      if (w_rise && (r_rise_cnt != C_MAX)) begin
        r_rise_cnt <= r_rise_cnt + C_ONE;
        if (r_rise_cnt == (C_MAX - C_ONE)) r_rise_ovf <= 1'b1;
      end
      if (w_fall && (r_fall_cnt != C_MAX)) begin
        r_fall_cnt <= r_fall_cnt + C_ONE;
        if (r_fall_cnt == (C_MAX - C_ONE)) r_fall_ovf <= 1'b1;
      end
    end
  end

  // High-time measurement; width latched into last_width on each falling edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_width_cnt  <= '0;
      r_last_width <= '0;
      r_width_ovf  <= 1'b0;
    end else if (w_clear) begin
      r_width_cnt  <= '0;
      r_last_width <= '0;
      r_width_ovf  <= 1'b0;
    end else begin
      if (w_rise) begin
        r_width_cnt <= C_ONE;
      end else if (w_lvl && (r_width_cnt != C_MAX)) begin
        r_width_cnt <= r_width_cnt + C_ONE;
      end
      if (w_fall) begin
        r_last_width <= r_width_cnt;
        if (r_width_cnt == C_MAX) r_width_ovf <= 1'b1;
      end
    end
  end

  // Register read mux, zero-extended to the bus width
  always_comb begin
    w_sel_val = '0;
    case (sel)
      SEL_RISE:   w_sel_val = 32'(r_rise_cnt);
      SEL_FALL:   w_sel_val = 32'(r_fall_cnt);
      SEL_WIDTH:  w_sel_val = 32'(r_last_width);
      SEL_STATUS: w_sel_val = {w_lvl, 28'b0, r_width_ovf, r_fall_ovf, r_rise_ovf};
      default:    w_sel_val = '0;
    endcase
  end

  // Handshake state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Handshake next-state and control decode
  always_comb begin
    w_next  = r_state;
    ack     = 1'b0;
    w_take  = 1'b0;
    w_clear = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req) begin
          w_take  = 1'b1;
          w_clear = (fn == FN_CLEAR);
          w_next  = ST_ACK;
        end
      end
      ST_ACK: begin
        ack    = 1'b1;
        w_next = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        ack = 1'b1;
        if (!req) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Snapshot of the selected register, taken when the request is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_snap <= '0;
    end else if (w_take) begin
      r_snap <= w_sel_val;
    end
  end

  assign rd_data = ack ? r_snap : 32'd0;

endmodule : bit_capture
`default_nettype wire

// File: tb/tb_bit_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_bit_capture
// Description : Self-checking bench for bit_capture. Two instances (16-bit
//               and 4-bit counters) share all inputs; expected values come
//               from event counts kept as plain integers and clamped to each
//               instance's counter range.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_capture;

  localparam int MAX_A = 65535;
  localparam int MAX_B = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din = 1'b0;
  logic        req = 1'b0;
  logic        fn  = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic        ack_a, ack_b;
  logic [31:0] rd_a, rd_b;

  int checks = 0;
  int errors = 0;

  // Reference model: raw event counts since the last clear/reset
  int rise_n = 0;
  int fall_n = 0;
  int last_w = 0;
  int max_w  = 0;
  bit lvl_m  = 1'b0;

  bit_capture #(.SYNC_STAGES(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .din(din), .req(req), .fn(fn), .sel(sel),
    .ack(ack_a), .rd_data(rd_a)
  );

  bit_capture #(.SYNC_STAGES(2), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .din(din), .req(req), .fn(fn), .sel(sel),
    .ack(ack_b), .rd_data(rd_b)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int v, input int mx);
    return (v < mx) ? v : mx;
  endfunction

  function automatic logic [31:0] expv(input logic [1:0] s, input int mx);
    case (s)
      2'd0:    return 32'(clamp(rise_n, mx));
      2'd1:    return 32'(clamp(fall_n, mx));
      2'd2:    return 32'(clamp(last_w, mx));
      default: return {lvl_m, 28'b0, (max_w >= mx), (fall_n >= mx), (rise_n >= mx)};
    endcase
  endfunction

  task automatic model_clear();
    rise_n = 0;
    fall_n = 0;
    last_w = 0;
    max_w  = 0;
  endtask

  // One full four-phase transaction with checks at every phase
  task automatic xact(input string tag, input logic f, input logic [1:0] s);
    logic [31:0] ea, eb;
    ea  = expv(s, MAX_A);
    eb  = expv(s, MAX_B);
    chk({tag, "_idle_ack"}, {31'b0, ack_a | ack_b}, 32'd0);
    req = 1'b1;
    fn  = f;
    sel = s;
    tick();
    chk({tag, "_ack_a"}, {31'b0, ack_a}, 32'd1);
    chk({tag, "_ack_b"}, {31'b0, ack_b}, 32'd1);
    chk({tag, "_data_a"}, rd_a, ea);
    chk({tag, "_data_b"}, rd_b, eb);
    req = 1'b0;
    fn  = 1'b0;
    sel = 2'($urandom_range(0, 3));
    tick();
    chk({tag, "_hold_ack"}, {31'b0, ack_a & ack_b}, 32'd1);
    chk({tag, "_hold_data_b"}, rd_b, eb);
    tick();
    chk({tag, "_ack_low"}, {31'b0, ack_a | ack_b}, 32'd0);
    chk({tag, "_data_zero"}, rd_a | rd_b, 32'd0);
    if (f) model_clear();
  endtask

  // High pulse of n sampled cycles on din, followed by settling time
  task automatic pulse(input int n);
    din = 1'b1;
    repeat (n) tick();
    din = 1'b0;
    rise_n++;
    fall_n++;
    last_w = n;
    if (n > max_w) max_w = n;
    repeat (4) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("reset_ack", {31'b0, ack_a | ack_b}, 32'd0);
    chk("reset_data", rd_a | rd_b, 32'd0);
    tick();
    rst = 1'b0;
    model_clear();
    lvl_m = 1'b0;
    tick();
  endtask

  initial begin
    // Idle after reset: every register reads zero
    rst = 1'b1;
    tick();
    chk("por_ack", {31'b0, ack_a | ack_b}, 32'd0);
    chk("por_data", rd_a | rd_b, 32'd0);
    rst = 1'b0;
    repeat (20) tick();
    xact("idle_rise", 1'b0, 2'd0);
    xact("idle_fall", 1'b0, 2'd1);
    xact("idle_width", 1'b0, 2'd2);
    xact("idle_status", 1'b0, 2'd3);

    // Three pulses of 5, 2, 7 cycles
    pulse(5);
    pulse(2);
    pulse(7);
    xact("p3_rise", 1'b0, 2'd0);
    xact("p3_fall", 1'b0, 2'd1);
    xact("p3_width", 1'b0, 2'd2);

    // 20 rising edges: the 4-bit counters saturate and flag overflow
    for (int i = 0; i < 20; i++) pulse(2);
    xact("sat_rise", 1'b0, 2'd0);
    xact("sat_status", 1'b0, 2'd3);
    xact("sat_clear", 1'b1, 2'd0);
    xact("post_clr_rise", 1'b0, 2'd0);
    xact("post_clr_status", 1'b0, 2'd3);

    // Long pulse saturates the width measurement
    pulse(40);
    xact("long_width", 1'b0, 2'd2);
    xact("long_status", 1'b0, 2'd3);

    // Randomized pulses interleaved with reads and occasional clears
    for (int i = 0; i < 12; i++) begin
      pulse(int'($urandom_range(1, 20)));
      repeat ($urandom_range(0, 3)) tick();
      xact("rand", ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)));
    end

    // Reset in the middle of a handshake drops ack immediately
    req = 1'b1;
    sel = 2'd0;
    tick();
    chk("midrst_ack_before", {31'b0, ack_a & ack_b}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_ack", {31'b0, ack_a | ack_b}, 32'd0);
    chk("midrst_data", rd_a | rd_b, 32'd0);
    req = 1'b0;
    tick();
    rst = 1'b0;
    model_clear();
    tick();
    xact("midrst_read", 1'b0, 2'd0);

    // Rising edge arriving on the same cycle as a clear is discarded
    pulse(3);
    din = 1'b1;
    tick();
    tick();
    req = 1'b1;
    fn  = 1'b1;
    sel = 2'd0;
    tick();
    chk("coinc_pre_clear", rd_b, 32'd1);
    model_clear();
    lvl_m = 1'b1;
    req = 1'b0;
    fn  = 1'b0;
    tick();
    tick();
    repeat (3) tick();
    xact("coinc_rise", 1'b0, 2'd0);
    xact("coinc_status", 1'b0, 2'd3);
    din = 1'b0;
    repeat (4) tick();
    do_reset();

    // din high while leaving reset registers as one rising edge
    din = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rise_n = 1;
    lvl_m  = 1'b1;
    repeat (5) tick();
    xact("rel_high_rise", 1'b0, 2'd0);
    xact("rel_high_status", 1'b0, 2'd3);

    // Request already high when leaving reset is served
    din = 1'b0;
    rst = 1'b1;
    req = 1'b1;
    sel = 2'd1;
    tick();
    rst = 1'b0;
    model_clear();
    lvl_m = 1'b0;
    tick();
    chk("req_at_release_ack", {31'b0, ack_a & ack_b}, 32'd1);
    chk("req_at_release_data", rd_a | rd_b, 32'd0);
    req = 1'b0;
    tick();
    tick();
    chk("req_at_release_done", {31'b0, ack_a | ack_b}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_bit_capture
`default_nettype wire
